// File: rtl/line_instruction_cache.sv
// Direct-mapped blocking instruction cache between fetcher and decoder, with line refill over a req/rsp port.
// Optional hit/miss counters are enabled by defining BGPU_ICACHE_STATS_EN.
module line_instruction_cache #(
    parameter int unsigned NumLines     = 16,
    parameter int unsigned LineInsts    = 4,
    parameter int unsigned PcWidth      = 32,
    parameter int unsigned NumWarps     = 8,
    parameter int unsigned WarpWidth    = 32,
    parameter int unsigned EncInstWidth = 32,
    localparam int unsigned OffW     = $clog2(LineInsts),
    localparam int unsigned IdxW     = $clog2(NumLines),
    localparam int unsigned TagW     = PcWidth - OffW - IdxW,
    localparam int unsigned WidWidth = $clog2(NumWarps)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    output logic                              ic_ready_o,
    input  logic                              fe_valid_i,
    input  logic [PcWidth-1:0]                fe_pc_i,
    input  logic [WarpWidth-1:0]              fe_act_mask_i,
    input  logic [WidWidth-1:0]               fe_warp_id_i,
    input  logic                              dec_ready_i,
    output logic                              ic_valid_o,
    output logic [PcWidth-1:0]                ic_pc_o,
    output logic [WarpWidth-1:0]              ic_act_mask_o,
    output logic [WidWidth-1:0]               ic_warp_id_o,
    output logic [EncInstWidth-1:0]           ic_inst_o,
    output logic                              mem_req_valid_o,
    input  logic                              mem_req_ready_i,
    output logic [PcWidth-1:0]                mem_req_addr_o,
    input  logic                              mem_rsp_valid_i,
    output logic                              mem_rsp_ready_o,
    input  logic [LineInsts*EncInstWidth-1:0] mem_rsp_data_i
`ifdef BGPU_ICACHE_STATS_EN
    ,
    output logic [31:0]                       hits_o,
    output logic [31:0]                       misses_o
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, REPLAY = 2'd3} state_e;

    function automatic logic [EncInstWidth-1:0] pick_inst(
        input logic [LineInsts*EncInstWidth-1:0] line,
        input logic [OffW-1:0]                   off
    );
        logic [EncInstWidth-1:0] inst;
        inst = '0;
        for (int k = 0; k < LineInsts; k++) begin
            if (off == OffW'(k)) begin
                inst = line[k*EncInstWidth +: EncInstWidth];
            end
        end
        return inst;
    endfunction

    state_e                            state_r, state_s;
    logic [NumLines-1:0]               valid_r;
    logic [TagW-1:0]                   tag_r  [NumLines];
    logic [LineInsts*EncInstWidth-1:0] data_r [NumLines];

    logic [PcWidth-1:0]      pend_pc_r;
    logic [WarpWidth-1:0]    pend_mask_r;
    logic [WidWidth-1:0]     pend_wid_r;

    logic                    ic_valid_r;
    logic [PcWidth-1:0]      ic_pc_r;
    logic [WarpWidth-1:0]    ic_mask_r;
    logic [WidWidth-1:0]     ic_wid_r;
    logic [EncInstWidth-1:0] ic_inst_r;
    logic                    mem_req_valid_r;
    logic                    mem_rsp_ready_r;

    logic [OffW-1:0] fe_off_s, pend_off_s;
    logic [IdxW-1:0] fe_idx_s, pend_idx_s;
    logic [TagW-1:0] fe_tag_s, pend_tag_s;
    logic            fe_hit_s, out_free_s, accept_s;
    logic            load_hit_s, load_miss_s, fill_s, load_replay_s;

    assign fe_off_s   = fe_pc_i[OffW-1:0];
    assign fe_idx_s   = fe_pc_i[OffW +: IdxW];
    assign fe_tag_s   = fe_pc_i[PcWidth-1 -: TagW];
    assign pend_off_s = pend_pc_r[OffW-1:0];
    assign pend_idx_s = pend_pc_r[OffW +: IdxW];
    assign pend_tag_s = pend_pc_r[PcWidth-1 -: TagW];

    assign fe_hit_s   = valid_r[fe_idx_s] && (tag_r[fe_idx_s] == fe_tag_s);
    assign out_free_s = !ic_valid_r || dec_ready_i;
    assign ic_ready_o = (state_r == IDLE) && out_free_s;
    assign accept_s   = ic_ready_o && fe_valid_i;

    assign ic_valid_o      = ic_valid_r;
    assign ic_pc_o         = ic_pc_r;
    assign ic_act_mask_o   = ic_mask_r;
    assign ic_warp_id_o    = ic_wid_r;
    assign ic_inst_o       = ic_inst_r;
    assign mem_req_valid_o = mem_req_valid_r;
    assign mem_rsp_ready_o = mem_rsp_ready_r;
    assign mem_req_addr_o  = {pend_pc_r[PcWidth-1:OffW], {OffW{1'b0}}};

    // Next-state and per-cycle action decode.
    always_comb begin
        state_s       = state_r;
        load_hit_s    = 1'b0;
        load_miss_s   = 1'b0;
        fill_s        = 1'b0;
        load_replay_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (fe_hit_s) begin
                        load_hit_s = 1'b1;
                    end else begin
                        load_miss_s = 1'b1;
                        state_s     = REQ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (mem_req_ready_i) state_s = WAIT;
                else                 state_s = REQ;
            end
            WAIT: begin
                if (mem_rsp_valid_i) begin
                    fill_s  = 1'b1;
                    state_s = REPLAY;
                end else begin
                    state_s = WAIT;
                end
            end
            REPLAY: begin
                if (out_free_s) begin
                    load_replay_s = 1'b1;
                    state_s       = IDLE;
                end else begin
                    state_s = REPLAY;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register plus memory handshake outputs registered from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r         <= IDLE;
            mem_req_valid_r <= 1'b0;
            mem_rsp_ready_r <= 1'b0;
        end else begin
            state_r         <= state_s;
            mem_req_valid_r <= (state_s == REQ);
            mem_rsp_ready_r <= (state_s == WAIT);
        end
    end

    // Line valid bits; a fill in the same cycle as a flush keeps its own line valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r <= '0;
        end else begin
            if (flush_i) valid_r <= '0;
            if (fill_s)  valid_r[pend_idx_s] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk_i) begin
        if (fill_s) begin
            tag_r[pend_idx_s]  <= pend_tag_s;
            data_r[pend_idx_s] <= mem_rsp_data_i;
        end
    end

    // Pending miss context, held until the replay.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_pc_r   <= '0;
            pend_mask_r <= '0;
            pend_wid_r  <= '0;
        end else if (load_miss_s) begin
            pend_pc_r   <= fe_pc_i;
            pend_mask_r <= fe_act_mask_i;
            pend_wid_r  <= fe_warp_id_i;
        end
    end

    // Decode-facing output register; fields only change on a load, valid drops on handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ic_valid_r <= 1'b0;
            ic_pc_r    <= '0;
            ic_mask_r  <= '0;
            ic_wid_r   <= '0;
            ic_inst_r  <= '0;
        end else if (load_hit_s) begin
            ic_valid_r <= 1'b1;
            ic_pc_r    <= fe_pc_i;
            ic_mask_r  <= fe_act_mask_i;
            ic_wid_r   <= fe_warp_id_i;
            ic_inst_r  <= pick_inst(data_r[fe_idx_s], fe_off_s);
        end else if (load_replay_s) begin
            ic_valid_r <= 1'b1;
            ic_pc_r    <= pend_pc_r;
            ic_mask_r  <= pend_mask_r;
            ic_wid_r   <= pend_wid_r;
            ic_inst_r  <= pick_inst(data_r[pend_idx_s], pend_off_s);
        end else if (dec_ready_i) begin
            ic_valid_r <= 1'b0;
        end
    end

`ifdef BGPU_ICACHE_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] hits_r, misses_r;
    assign hits_o   = hits_r;
    assign misses_o = misses_r;

    // Saturating counters of accepted fetches split by hit/miss.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hits_r   <= 32'd0;
            misses_r <= 32'd0;
        end else begin
            if (load_hit_s)  hits_r   <= sat_inc(hits_r);
            if (load_miss_s) misses_r <= sat_inc(misses_r);
        end
    end
`endif

endmodule

// File: tb/tb_line_instruction_cache.sv
// Directed scoreboard bench for line_instruction_cache: fetch stimulus pushes expected
// outputs into a queue, a negedge monitor pops and compares on every decode handshake.
module tb_line_instruction_cache;

    localparam int LW = 4 * 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush_i, ic_ready_o, fe_valid_i, dec_ready_i, ic_valid_o;
    logic [31:0]   fe_pc_i, fe_act_mask_i, ic_pc_o, ic_act_mask_o, ic_inst_o;
    logic [2:0]    fe_warp_id_i, ic_warp_id_o;
    logic          mem_req_valid_o, mem_req_ready_i, mem_rsp_valid_i, mem_rsp_ready_o;
    logic [31:0]   mem_req_addr_o;
    logic [LW-1:0] mem_rsp_data_i;
`ifdef BGPU_ICACHE_STATS_EN
    logic [31:0]   hits_o, misses_o;
    logic [31:0]   h0, m0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] mask;
        logic [2:0]  wid;
        logic [31:0] inst;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e, mon_g;

    line_instruction_cache dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i), .ic_ready_o(ic_ready_o),
        .fe_valid_i(fe_valid_i), .fe_pc_i(fe_pc_i), .fe_act_mask_i(fe_act_mask_i),
        .fe_warp_id_i(fe_warp_id_i), .dec_ready_i(dec_ready_i), .ic_valid_o(ic_valid_o),
        .ic_pc_o(ic_pc_o), .ic_act_mask_o(ic_act_mask_o), .ic_warp_id_o(ic_warp_id_o),
        .ic_inst_o(ic_inst_o), .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i), .mem_req_addr_o(mem_req_addr_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
        .mem_rsp_data_i(mem_rsp_data_i)
`ifdef BGPU_ICACHE_STATS_EN
        , .hits_o(hits_o), .misses_o(misses_o)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: a decode handshake happens at the next posedge.
    always @(negedge clk) begin
        if (rst_n && ic_valid_o && dec_ready_i) begin
            checks++;
            mon_g = '{ic_pc_o, ic_act_mask_o, ic_warp_id_o, ic_inst_o};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got pc=%h inst=%h required no output", ic_pc_o, ic_inst_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_g !== mon_e)
                begin
                    errors++;
                    $display("FAIL sb_output got pc=%h mask=%h wid=%0d inst=%h required pc=%h mask=%h wid=%0d inst=%h",
                             mon_g.pc, mon_g.mask, mon_g.wid, mon_g.inst,
                             mon_e.pc, mon_e.mask, mon_e.wid, mon_e.inst);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    function automatic logic [LW-1:0] mk_line(input logic [31:0] i0, input logic [31:0] i1,
                                              input logic [31:0] i2, input logic [31:0] i3);
        return {i3, i2, i1, i0};
    endfunction

    // Issue one fetch once the cache is ready; queue its expected output.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] mask, input logic [2:0] wid,
                         input logic [31:0] inst, output int waited);
        waited = 0;
        while (!ic_ready_o && waited < 40) begin
            tick();
            waited++;
        end
        if (!ic_ready_o) begin
            checks++;
            errors++;
            $display("FAIL fetch_ready_timeout got 0 required 1");
        end
        exp_q.push_back('{pc, mask, wid, inst});
        fe_valid_i = 1'b1; fe_pc_i = pc; fe_act_mask_i = mask; fe_warp_id_i = wid;
        tick();
        fe_valid_i = 1'b0;
    endtask

    // Memory responder: checks the request, optionally stalls it, then returns a line.
    task automatic serve(input logic [31:0] addr, input logic [LW-1:0] line,
                         input int stall, input logic flush_at_rsp);
        int n = 0;
        while (!mem_req_valid_o && n < 20) begin tick(); n++; end
        chk("mem_req_valid", {63'd0, mem_req_valid_o}, 64'd1);
        chk("mem_req_addr", {32'd0, mem_req_addr_o}, {32'd0, addr});
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_req_valid", {63'd0, mem_req_valid_o}, 64'd1);
            chk("stall_req_addr", {32'd0, mem_req_addr_o}, {32'd0, addr});
        end
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        n = 0;
        while (!mem_rsp_ready_o && n < 20) begin tick(); n++; end
        chk("mem_rsp_ready", {63'd0, mem_rsp_ready_o}, 64'd1);
        mem_rsp_valid_i = 1'b1; mem_rsp_data_i = line; flush_i = flush_at_rsp;
        tick();
        mem_rsp_valid_i = 1'b0; flush_i = 1'b0;
        chk("rsp_done_req_idle", {62'd0, mem_req_valid_o, mem_rsp_ready_o}, 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin tick(); n++; end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    logic [LW-1:0] line_a, line_5, line_20, line_24, line_30;
    int w;

    initial begin
        line_a  = mk_line(32'hA, 32'hB, 32'hC, 32'hD);
        line_5  = mk_line(32'h5000, 32'h5001, 32'h5002, 32'h5003);
        line_20 = mk_line(32'h2000, 32'h2001, 32'h2002, 32'h2003);
        line_24 = mk_line(32'h2400, 32'h2401, 32'h2402, 32'h2403);
        line_30 = mk_line(32'h3000, 32'h3001, 32'h3002, 32'h3003);
        rst_n = 1'b0; flush_i = 1'b0; fe_valid_i = 1'b0; fe_pc_i = 32'd0;
        fe_act_mask_i = 32'd0; fe_warp_id_i = 3'd0; dec_ready_i = 1'b1;
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_ic_valid", {63'd0, ic_valid_o}, 64'd0);
        chk("rst_ic_ready", {63'd0, ic_ready_o}, 64'd1);
        chk("rst_mem_hs", {62'd0, mem_req_valid_o, mem_rsp_ready_o}, 64'd0);
        chk("rst_ic_data", {ic_pc_o, ic_inst_o}, 64'd0);
`ifdef BGPU_ICACHE_STATS_EN
        chk("rst_stats", {hits_o, misses_o}, 64'd0);
`endif

        // Cold miss
        fetch(32'h13, 32'hF0F0_1234, 3'd3, 32'hD, w);
        chk("miss_blocks_ready", {63'd0, ic_ready_o}, 64'd0);
        serve(32'h10, line_a, 0, 1'b0);
        tick();
        chk("replay_valid", {63'd0, ic_valid_o}, 64'd1);
        drain();

        // Back-to-back hits, one per cycle
        fetch(32'h10, 32'h1, 3'd1, 32'hA, w);
        chk("hit_latency", {63'd0, ic_valid_o}, 64'd1);
        fetch(32'h11, 32'h2, 3'd2, 32'hB, w);
        chk("hit_stream_nowait1", 64'(w), 64'd0);
        fetch(32'h12, 32'h4, 3'd4, 32'hC, w);
        chk("hit_stream_nowait2", 64'(w), 64'd0);
        chk("hit_no_mem_req", {63'd0, mem_req_valid_o}, 64'd0);
        drain();

        // Conflict eviction on index 4
        fetch(32'h50, 32'hFFFF_FFFF, 3'd5, 32'h5000, w);
        serve(32'h50, line_5, 0, 1'b0);
        drain();
        fetch(32'h10, 32'h8, 3'd6, 32'hA, w);
        chk("evicted_refetch_miss", {63'd0, ic_ready_o}, 64'd0);
        serve(32'h10, line_a, 0, 1'b0);
        drain();

        // Back-pressure on a hit
        dec_ready_i = 1'b0;
        fetch(32'h11, 32'h55AA, 3'd7, 32'hB, w);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {ic_valid_o, ic_ready_o, 30'd0, ic_pc_o[3:0], ic_inst_o[27:0]},
                {1'b1, 1'b0, 30'd0, 4'h1, 28'hB});
            tick();
        end
        dec_ready_i = 1'b1;
        drain();

        // Miss completing while decode is stalled
        fetch(32'h20, 32'h77, 3'd2, 32'h2000, w);
        dec_ready_i = 1'b0;
        serve(32'h20, line_20, 0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("bp_miss_hold", {ic_valid_o, ic_ready_o, 30'd0, ic_inst_o},
                {1'b1, 1'b0, 30'd0, 32'h2000});
            tick();
        end
        dec_ready_i = 1'b1;
        drain();

        // Flush invalidates the line
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        fetch(32'h10, 32'h9, 3'd1, 32'hA, w);
        chk("flush_then_miss", {63'd0, ic_ready_o}, 64'd0);
        serve(32'h10, line_a, 0, 1'b0);
        drain();

        // Flush coinciding with a fill keeps only the filled line
        fetch(32'h24, 32'h3, 3'd3, 32'h2400, w);
        serve(32'h24, line_24, 0, 1'b1);
        drain();
        fetch(32'h26, 32'h6, 3'd6, 32'h2402, w);
        chk("fill_wins_hit", {62'd0, ic_valid_o, ic_ready_o}, 64'd3);
        drain();
        fetch(32'h10, 32'hA, 3'd0, 32'hA, w);
        chk("flushed_line_misses", {63'd0, ic_ready_o}, 64'd0);
        serve(32'h10, line_a, 0, 1'b0);
        drain();
        fetch(32'h20, 32'hB, 3'd1, 32'h2000, w);
        chk("flushed_line2_misses", {63'd0, ic_ready_o}, 64'd0);
        serve(32'h20, line_20, 0, 1'b0);
        drain();

        // Memory request stall
`ifdef BGPU_ICACHE_STATS_EN
        h0 = hits_o; m0 = misses_o;
`endif
        fetch(32'h31, 32'hC0DE, 3'd4, 32'h3001, w);
        serve(32'h30, line_30, 4, 1'b0);
        drain();
`ifdef BGPU_ICACHE_STATS_EN
        chk("stall_stats", {hits_o, misses_o}, {h0, m0 + 32'd1});
        chk("final_stats", {hits_o, misses_o}, {32'd5, 32'd9});
`endif

        repeat (3) tick();
        chk("end_idle", {62'd0, ic_valid_o, ic_ready_o}, 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
